// File: rtl/vga_sync_gen.sv
// Pixel-rate divider plus horizontal/vertical counters for a VGA raster.
// Sync, blanking and line/frame pulses are registered so they line up with pixel_x/pixel_y.
module vga_sync_gen #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int CLK_DIV   = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic       p_tick,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       video_on,
  output logic       hsync,
  output logic       vsync,
  output logic       line_start,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0]  Q_LAST   = 4'(CLK_DIV - 1);
  localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
  // Window bounds are 11 bits so a bound equal to 1024 still compares correctly.
  localparam logic [10:0] H_VIS    = 11'(H_DISPLAY);
  localparam logic [10:0] V_VIS    = 11'(V_DISPLAY);
  localparam logic [10:0] HS_BEGIN = 11'(H_DISPLAY + H_FRONT);
  localparam logic [10:0] HS_END   = 11'(H_DISPLAY + H_FRONT + H_SYNC);
  localparam logic [10:0] VS_BEGIN = 11'(V_DISPLAY + V_FRONT);
  localparam logic [10:0] VS_END   = 11'(V_DISPLAY + V_FRONT + V_SYNC);

  logic [3:0]  q_reg, q_next;
  logic [9:0]  x_reg, x_next;
  logic [9:0]  y_reg, y_next;
  logic        hsync_reg, vsync_reg, video_on_reg;
  logic        line_start_reg, frame_start_reg;
  logic        tick, h_wrap, v_wrap;
  logic [10:0] x_ext, y_ext;

  always_comb begin
    tick   = (q_reg == Q_LAST);
    h_wrap = tick && (x_reg == H_LAST);
    v_wrap = h_wrap && (y_reg == V_LAST);
    q_next = tick ? 4'd0 : q_reg + 4'd1;
    x_next = x_reg;
    y_next = y_reg;
    if (h_wrap) begin
      x_next = 10'd0;
    end else if (tick) begin
      x_next = x_reg + 10'd1;
    end
    if (v_wrap) begin
      y_next = 10'd0;
    end else if (h_wrap) begin
      y_next = y_reg + 10'd1;
    end
    x_ext = {1'b0, x_next};
    y_ext = {1'b0, y_next};
  end

  // Decodes use the next-state counts so they change on the same edge as the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg           <= 4'd0;
      x_reg           <= 10'd0;
      y_reg           <= 10'd0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      video_on_reg    <= 1'b1;
      line_start_reg  <= 1'b0;
      frame_start_reg <= 1'b0;
    end else begin
      q_reg           <= q_next;
      x_reg           <= x_next;
      y_reg           <= y_next;
      hsync_reg       <= !((x_ext >= HS_BEGIN) && (x_ext < HS_END));
      vsync_reg       <= !((y_ext >= VS_BEGIN) && (y_ext < VS_END));
      video_on_reg    <= (x_ext < H_VIS) && (y_ext < V_VIS);
      line_start_reg  <= h_wrap;
      frame_start_reg <= v_wrap;
    end
  end

  assign p_tick      = tick && !rst;
  assign pixel_x     = x_reg;
  assign pixel_y     = y_reg;
  assign hsync       = hsync_reg;
  assign vsync       = vsync_reg;
  assign video_on    = video_on_reg;
  assign line_start  = line_start_reg;
  assign frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen on a shrunken raster (24x13 pixels, 3 clks/pixel) so whole frames fit the run.
// Every output is predicted from the number of clocks elapsed since reset.
module tb_vga_sync_gen;

  localparam int HD = 12, HF = 3, HS = 4, HB = 5;
  localparam int VD = 6,  VF = 2, VS = 2, VB = 3;
  localparam int D  = 3;
  localparam int HT = HD + HF + HS + HB;   // 24
  localparam int VT = VD + VF + VS + VB;   // 13

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       p_tick, video_on, hsync, vsync, line_start, frame_start;
  logic [9:0] pixel_x, pixel_y;

  int n_checks = 0;
  int n_fail   = 0;

  vga_sync_gen #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .CLK_DIV(D)
  ) dut (
    .clk(clk), .rst(rst), .p_tick(p_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .video_on(video_on), .hsync(hsync), .vsync(vsync),
    .line_start(line_start), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference state: clock edges since the last reset edge.
  longint k = 0;
  bit model_valid = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      k           <= 0;
      model_valid <= 1'b1;
    end else begin
      k <= k + 1;
    end
  end

  always @(negedge clk) begin
    longint n, q, x, y;
    bit e_ls;
    if (model_valid) begin
      n    = k / D;
      q    = k % D;
      x    = n % HT;
      y    = (n / HT) % VT;
      e_ls = (k > 0) && (q == 0) && (x == 0);
      check("pixel_x", pixel_x, x);
      check("pixel_y", pixel_y, y);
      check("p_tick", p_tick, longint'((q == D - 1) && !rst));
      check("hsync", hsync, longint'(!(x >= HD + HF && x < HD + HF + HS)));
      check("vsync", vsync, longint'(!(y >= VD + VF && y < VD + VF + VS)));
      check("video_on", video_on, longint'(x < HD && y < VD));
      check("line_start", line_start, longint'(e_ls));
      check("frame_start", frame_start, longint'(e_ls && y == 0));
    end
  end

  initial begin
    int hs_cnt, vs_cnt, ls_cnt, fs_first, fs_second, hold;
    bit found;
    hs_cnt = 0; vs_cnt = 0; ls_cnt = 0; fs_first = -1; fs_second = -1;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Directed run from reset over two frames; e is the edge number after release.
    for (int e = 1; e <= 1900; e++) begin
      @(posedge clk);
      @(negedge clk);
      if (e == 1) check("p_tick_edge1", p_tick, 0);
      if (e == 2) check("p_tick_edge2", p_tick, 1);
      if (e == 2) check("pixel_x_edge2", pixel_x, 0);
      if (e == 3) check("pixel_x_edge3", pixel_x, 1);
      if (e == 3) check("p_tick_edge3", p_tick, 0);
      if (e == 5) check("p_tick_edge5", p_tick, 1);
      if (e <= 935 && vsync == 1'b0) vs_cnt++;
      if (e <= 935 && pixel_y == 10'd0 && hsync == 1'b0) hs_cnt++;
      if (e <= 936 && line_start) ls_cnt++;
      if (frame_start) begin
        if (fs_first < 0) fs_first = e;
        else if (fs_second < 0) fs_second = e;
      end
    end
    check("hsync_low_clks_line0", hs_cnt, 12);
    check("vsync_low_clks_frame", vs_cnt, 144);
    check("line_starts_frame", ls_cnt, 13);
    check("first_frame_start_edge", fs_first, 936);
    check("frame_period", fs_second - fs_first, 936);

    // One-clock reset in mid-frame at pixel (17,4).
    found = 1'b0;
    for (int c = 0; c < 2000 && !found; c++) begin
      @(negedge clk);
      if (pixel_x == 10'd17 && pixel_y == 10'd4) found = 1'b1;
    end
    check("reach_pixel_17_4", found, 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_x", pixel_x, 0);
    check("midrst_y", pixel_y, 0);
    check("midrst_hsync", hsync, 1);
    check("midrst_vsync", vsync, 1);
    check("midrst_pulses", {line_start, frame_start}, 0);
    @(negedge clk); check("midrst_p_tick_edge1", p_tick, 0);
    @(negedge clk); check("midrst_p_tick_edge2", p_tick, 1);
    @(negedge clk); check("midrst_x_edge3", pixel_x, 1);

    // Random run with occasional short resets; the per-clock checker does the work.
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk);
      #1;
      if (!rst && $urandom_range(0, 599) == 0) begin
        rst  = 1'b1;
        hold = $urandom_range(1, 3);
      end else if (rst) begin
        hold--;
        if (hold <= 0) rst = 1'b0;
      end
    end
    @(posedge clk); #1 rst = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
